// File: rtl/decimal_entry_pkg.sv
// Shared definitions for the decimal entry path: FSM state codes, digit limit
// and the two-digit decimal-to-binary helpers.
package decimal_entry_pkg;

  localparam logic [1:0] S_TENS = 2'd0;
  localparam logic [1:0] S_ONES = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] MAX_DIGIT = 4'd9;

  function automatic logic digit_ok(input logic [3:0] d);
    return (d <= MAX_DIGIT);
  endfunction

  // Tens*10 as shift-and-add, all terms at 7 bits; 9*10+9 = 99 fits.
  function automatic logic [6:0] bcd2_to_bin(input logic [3:0] tens,
                                             input logic [3:0] ones);
    return {tens, 3'b000} + {2'b00, tens, 1'b0} + {3'b000, ones};
  endfunction

endpackage

// File: rtl/decimal_entry_key_debounce.sv
// Synchronise and debounce one active-low pushbutton; emit a single-cycle
// pulse when the accepted level goes from released to pressed.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int CNT_W           = 19
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Key_Raw,
  output logic Press
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             r_press;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= Key_Raw;
      r_sync2 <= r_sync1;
    end
  end

  // Counter runs only while the synced level disagrees with the accepted one,
  // so any bounce shorter than DEBOUNCE_CYCLES restarts it from zero.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_level <= 1'b1;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
        r_press <= r_level & ~r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign Press = r_press;

endmodule

// File: rtl/decimal_entry.sv
// Two-digit decimal entry: debounced Enter/Clear keys drive a tens/ones FSM
// that produces a registered binary value 0..99 with display echo digits.
module decimal_entry
  import decimal_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int CNT_W           = 19
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [3:0] Digit,
  input  logic       Key_Enter,
  input  logic       Key_Clear,
  output logic [6:0] Value,
  output logic [3:0] Tens,
  output logic [3:0] Ones,
  output logic       Valid,
  output logic       Done,
  output logic       Error
);

  logic       w_enter;
  logic       w_clear;
  logic       w_dig_ok;
  logic [6:0] w_value;

  logic [3:0] r_dig_s1;
  logic [3:0] r_dig_s2;
  logic [1:0] r_state;
  logic [6:0] r_value;
  logic [3:0] r_tens;
  logic [3:0] r_ones;
  logic       r_valid;
  logic       r_done;
  logic       r_error;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db_enter (
    .Clk    (Clk),
    .Rst    (Rst),
    .Key_Raw(Key_Enter),
    .Press  (w_enter)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db_clear (
    .Clk    (Clk),
    .Rst    (Rst),
    .Key_Raw(Key_Clear),
    .Press  (w_clear)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_dig_s1 <= '0;
      r_dig_s2 <= '0;
    end else begin
      r_dig_s1 <= Digit;
      r_dig_s2 <= r_dig_s1;
    end
  end

  assign w_dig_ok = digit_ok(r_dig_s2);
  assign w_value  = bcd2_to_bin(r_tens, r_dig_s2);

  // Clear is tested first so a coincident Enter pulse is discarded.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= S_TENS;
      r_value <= '0;
      r_tens  <= '0;
      r_ones  <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_clear) begin
        r_state <= S_TENS;
        r_value <= '0;
        r_tens  <= '0;
        r_ones  <= '0;
        r_valid <= 1'b0;
        r_error <= 1'b0;
      end else begin
        case (r_state)
          S_TENS, S_DONE: begin
            if (w_enter) begin
              if (w_dig_ok) begin
                r_tens  <= r_dig_s2;
                r_ones  <= '0;
                r_error <= 1'b0;
                r_valid <= 1'b0;
                r_state <= S_ONES;
              end else begin
                r_error <= 1'b1;
              end
            end
          end
          S_ONES: begin
            if (w_enter) begin
              if (w_dig_ok) begin
                r_ones  <= r_dig_s2;
                r_value <= w_value;
                r_valid <= 1'b1;
                r_done  <= 1'b1;
                r_error <= 1'b0;
                r_state <= S_DONE;
              end else begin
                r_error <= 1'b1;
              end
            end
          end
          default: r_state <= S_TENS;
        endcase
      end
    end
  end

  assign Value = r_value;
  assign Tens  = r_tens;
  assign Ones  = r_ones;
  assign Valid = r_valid;
  assign Done  = r_done;
  assign Error = r_error;

endmodule

// File: tb/tb_decimal_entry.sv
// Directed bench for decimal_entry with a short debounce window.
module tb_decimal_entry;

  logic       Clk;
  logic       Rst;
  logic [3:0] Digit;
  logic       Key_Enter;
  logic       Key_Clear;
  logic [6:0] Value;
  logic [3:0] Tens;
  logic [3:0] Ones;
  logic       Valid;
  logic       Done;
  logic       Error;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  decimal_entry #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Digit    (Digit),
    .Key_Enter(Key_Enter),
    .Key_Clear(Key_Clear),
    .Value    (Value),
    .Tens     (Tens),
    .Ones     (Ones),
    .Valid    (Valid),
    .Done     (Done),
    .Error    (Error)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    #2;
    if (Done === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic press_enter(input logic [3:0] d);
    Digit = d;
    cyc(4);
    Key_Enter = 1'b0;
    cyc(10);
    Key_Enter = 1'b1;
    cyc(10);
  endtask

  task automatic press_clear();
    Key_Clear = 1'b0;
    cyc(10);
    Key_Clear = 1'b1;
    cyc(10);
  endtask

  task automatic press_both(input logic [3:0] d);
    Digit = d;
    cyc(4);
    Key_Enter = 1'b0;
    Key_Clear = 1'b0;
    cyc(10);
    Key_Enter = 1'b1;
    Key_Clear = 1'b1;
    cyc(10);
  endtask

  initial begin
    Rst = 1'b1;
    Digit = 4'd0;
    Key_Enter = 1'b1;
    Key_Clear = 1'b1;
    cyc(3);
    Rst = 1'b0;
    cyc(2);
    check("rst_value", 8'(Value), 8'd0);
    check("rst_tens",  8'(Tens),  8'd0);
    check("rst_ones",  8'(Ones),  8'd0);
    check("rst_valid", 8'(Valid), 8'd0);
    check("rst_done",  8'(Done),  8'd0);
    check("rst_error", 8'(Error), 8'd0);

    // Clean entry 4,2
    press_enter(4'd4);
    check("t1_tens_first",  8'(Tens),  8'd4);
    check("t1_valid_first", 8'(Valid), 8'd0);
    press_enter(4'd2);
    check("t1_value", 8'(Value), 8'd42);
    check("t1_tens",  8'(Tens),  8'd4);
    check("t1_ones",  8'(Ones),  8'd2);
    check("t1_valid", 8'(Valid), 8'd1);
    check("t1_done_count", 8'(done_cnt), 8'd1);

    // New entry from S_DONE, then Clear mid-entry
    press_enter(4'd5);
    check("t5_tens",       8'(Tens),  8'd5);
    check("t5_valid_drop", 8'(Valid), 8'd0);
    check("t5_value_kept", 8'(Value), 8'd42);
    press_clear();
    check("t5_clr_tens",  8'(Tens),  8'd0);
    check("t5_clr_value", 8'(Value), 8'd0);
    check("t5_clr_valid", 8'(Valid), 8'd0);
    check("t5_clr_done",  8'(done_cnt), 8'd1);

    // Invalid digits
    press_enter(4'd12);
    check("t3_err_set",  8'(Error), 8'd1);
    check("t3_tens_hold", 8'(Tens), 8'd0);
    press_enter(4'd7);
    check("t3_err_clr", 8'(Error), 8'd0);
    check("t3_tens",    8'(Tens),  8'd7);
    press_enter(4'd13);
    check("t3_ones_err",      8'(Error), 8'd1);
    check("t3_ones_tenskept", 8'(Tens),  8'd7);
    check("t3_ones_novalid",  8'(Valid), 8'd0);
    press_enter(4'd1);
    check("t3_value", 8'(Value), 8'd71);
    check("t3_err_after", 8'(Error), 8'd0);
    check("t3_done_count", 8'(done_cnt), 8'd2);

    // Extremes
    press_enter(4'd9);
    press_enter(4'd9);
    check("t4_value99", 8'(Value), 8'd99);
    check("t4_done99",  8'(done_cnt), 8'd3);
    press_enter(4'd0);
    press_enter(4'd0);
    check("t4_value0", 8'(Value), 8'd0);
    check("t4_valid0", 8'(Valid), 8'd1);
    check("t4_done0",  8'(done_cnt), 8'd4);

    // Bounce: 5 low/high pairs of 2 cycles, then hold low
    Digit = 4'd6;
    cyc(4);
    for (int i = 0; i < 5; i++) begin
      Key_Enter = 1'b0;
      cyc(2);
      Key_Enter = 1'b1;
      cyc(2);
    end
    check("t2_no_early", 8'(Tens), 8'd0);
    Key_Enter = 1'b0;
    cyc(6);
    check("t2_not_yet", 8'(Tens), 8'd0);
    cyc(1);
    check("t2_tens",      8'(Tens),  8'd6);
    check("t2_valid_drop", 8'(Valid), 8'd0);
    cyc(10);
    Key_Enter = 1'b1;
    cyc(10);
    press_enter(4'd8);
    check("t2_value", 8'(Value), 8'd68);
    check("t2_done_count", 8'(done_cnt), 8'd5);

    // Clear and Enter on the same cycle while in S_ONES
    press_enter(4'd5);
    check("t5b_tens", 8'(Tens), 8'd5);
    press_both(4'd3);
    check("t5b_tens_clr", 8'(Tens),  8'd0);
    check("t5b_ones_clr", 8'(Ones),  8'd0);
    check("t5b_value",    8'(Value), 8'd0);
    check("t5b_valid",    8'(Valid), 8'd0);
    check("t5b_no_done",  8'(done_cnt), 8'd5);
    press_enter(4'd2);
    press_enter(4'd3);
    check("t5b_reentry", 8'(Value), 8'd23);

    // Reset mid-entry, re-entry, then new entry from S_DONE
    press_enter(4'd4);
    check("t6_tens_pre", 8'(Tens), 8'd4);
    Rst = 1'b1;
    cyc(1);
    Rst = 1'b0;
    cyc(1);
    check("t6_rst_value", 8'(Value), 8'd0);
    check("t6_rst_tens",  8'(Tens),  8'd0);
    check("t6_rst_valid", 8'(Valid), 8'd0);
    check("t6_rst_error", 8'(Error), 8'd0);
    press_enter(4'd3);
    press_enter(4'd1);
    check("t6_value31", 8'(Value), 8'd31);
    check("t6_valid31", 8'(Valid), 8'd1);
    press_enter(4'd6);
    check("t6_valid_drop", 8'(Valid), 8'd0);
    check("t6_value_kept", 8'(Value), 8'd31);
    check("t6_tens_new",   8'(Tens),  8'd6);
    check("t6_done_count", 8'(done_cnt), 8'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
